// File: rtl/adaptive_threshold_if.sv
// adaptive_threshold_if: start/status handshake plus source, mean and result memory ports.
interface adaptive_threshold_if #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
);
    logic                   start;
    logic                   busy;
    logic                   finished;
    logic [WIDTH_BITS-1:0]  oImageCol;
    logic [HEIGHT_BITS-1:0] oImageRow;
    logic [7:0]             iImageData;
    logic [WIDTH_BITS-1:0]  oMeanCol;
    logic [HEIGHT_BITS-1:0] oMeanRow;
    logic [7:0]             iMeanData;
    logic [WIDTH_BITS-1:0]  oResultCol;
    logic [HEIGHT_BITS-1:0] oResultRow;
    logic [7:0]             oResultData;
    logic                   oResultWren;

    modport master (
        input  start, iImageData, iMeanData,
        output busy, finished, oImageCol, oImageRow, oMeanCol, oMeanRow,
               oResultCol, oResultRow, oResultData, oResultWren
    );

    modport slave (
        output start, iImageData, iMeanData,
        input  busy, finished, oImageCol, oImageRow, oMeanCol, oMeanRow,
               oResultCol, oResultRow, oResultData, oResultWren
    );
endinterface

// File: rtl/adaptive_threshold.sv
// adaptive_threshold: binarises each pixel against its 3x3 local mean, one pixel per clock.
// Optional ADAPTIVE_THRESHOLD_OFFSET_EN lowers the threshold by C, saturating at 0.
module adaptive_threshold #(
    parameter int         WIDTH_BITS  = 8,
    parameter int         HEIGHT_BITS = 8,
    parameter int         WIDTH       = 2**WIDTH_BITS,
    parameter int         HEIGHT      = 2**HEIGHT_BITS,
    parameter logic [7:0] C           = 8'd2
) (
    input logic                  clock,
    input logic                  reset,
    adaptive_threshold_if.master bus
);
    localparam int              PB   = WIDTH_BITS + HEIGHT_BITS;
    localparam logic [PB-1:0]   LAST = PB'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          r_state, w_next;
    logic [PB-1:0]   r_rd_pos, r_wr_pos, r_res_pos;
    logic            r_rd_valid, r_wren;
    logic [7:0]      r_res_data, w_thr;
    logic            w_fg;

`ifdef ADAPTIVE_THRESHOLD_OFFSET_EN
    logic signed [8:0] w_diff;
    assign w_diff = $signed({1'b0, bus.iMeanData}) - $signed({1'b0, C});
    assign w_thr  = w_diff[8] ? 8'd0 : w_diff[7:0];
`else
    logic w_unused_c;
    assign w_unused_c = ^C;
    assign w_thr      = bus.iMeanData;
`endif

    assign w_fg = {1'b0, bus.iImageData} > {1'b0, w_thr};

    always_ff @(posedge clock or negedge reset)
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;

    // DONE holds until the final strobe has retired so finished is never skipped
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? RUN : IDLE;
            RUN:     w_next = (r_rd_pos == LAST) ? DRAIN : RUN;
            DRAIN:   w_next = DONE;
            DONE:    w_next = (!bus.start && !r_wren) ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_pos   <= '0;
            r_wr_pos   <= '0;
            r_rd_valid <= 1'b0;
            r_wren     <= 1'b0;
            r_res_pos  <= '0;
            r_res_data <= 8'd0;
        end else begin
            r_rd_pos   <= (r_state == IDLE) ? '0 :
                          (r_state == RUN && r_rd_pos != LAST) ? r_rd_pos + 1'b1 : r_rd_pos;
            r_wr_pos   <= r_rd_pos;
            r_rd_valid <= (r_state == RUN);
            r_wren     <= r_rd_valid;
            if (r_rd_valid) begin
                r_res_pos  <= r_wr_pos;
                r_res_data <= w_fg ? 8'hFF : 8'h00;
            end
        end
    end

    assign bus.oImageCol   = r_rd_pos[WIDTH_BITS-1:0];
    assign bus.oImageRow   = r_rd_pos[PB-1:WIDTH_BITS];
    assign bus.oMeanCol    = r_rd_pos[WIDTH_BITS-1:0];
    assign bus.oMeanRow    = r_rd_pos[PB-1:WIDTH_BITS];
    assign bus.oResultCol  = r_res_pos[WIDTH_BITS-1:0];
    assign bus.oResultRow  = r_res_pos[PB-1:WIDTH_BITS];
    assign bus.oResultData = r_res_data;
    assign bus.oResultWren = r_wren;
    assign bus.busy        = (r_state == RUN) || (r_state == DRAIN) || r_wren;
    assign bus.finished    = (r_state == DONE) && !r_wren;
endmodule

// File: tb/tb_adaptive_threshold.sv
// tb_adaptive_threshold: directed 4x4 runs against a 1-cycle-latency memory model.
module tb_adaptive_threshold;
    localparam int N = 16;
    localparam logic [7:0] CV = 8'd2;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] img [N];
    logic [7:0] mean [N];

    adaptive_threshold_if #(.WIDTH_BITS(2), .HEIGHT_BITS(2)) bus ();

    adaptive_threshold #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .C(CV)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        bus.iImageData <= img[{bus.oImageRow, bus.oImageCol}];
        bus.iMeanData  <= mean[{bus.oMeanRow, bus.oMeanCol}];
    end

    function automatic logic [7:0] model(input logic [7:0] pix, input logic [7:0] mn);
        logic [7:0] thr;
`ifdef ADAPTIVE_THRESHOLD_OFFSET_EN
        thr = (mn >= CV) ? mn - CV : 8'd0;
`else
        thr = mn;
`endif
        return (pix > thr) ? 8'd255 : 8'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts a run and checks every cycle 0..N+2; hold keeps start high through DONE
    task automatic run(input string tag, input bit hold);
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (!hold) bus.start = 1'b0;
        for (int k = 0; k <= N + 2; k++) begin
            if (k < N) begin
                chk($sformatf("%s_rdaddr%0d", tag, k), {28'd0, bus.oImageRow, bus.oImageCol}, k);
                chk($sformatf("%s_meanaddr%0d", tag, k), {28'd0, bus.oMeanRow, bus.oMeanCol}, k);
            end
            chk($sformatf("%s_wren%0d", tag, k), bus.oResultWren, (k >= 2 && k <= N + 1));
            if (k >= 2 && k <= N + 1) begin
                chk($sformatf("%s_col%0d", tag, k), bus.oResultCol, (k - 2) % 4);
                chk($sformatf("%s_row%0d", tag, k), bus.oResultRow, (k - 2) / 4);
                chk($sformatf("%s_data%0d", tag, k), bus.oResultData, model(img[k-2], mean[k-2]));
            end
            chk($sformatf("%s_busy%0d", tag, k), bus.busy, (k <= N + 1));
            chk($sformatf("%s_fin%0d", tag, k), bus.finished, (k == N + 2));
            @(negedge clock);
        end
        if (hold) begin
            repeat (3) begin
                chk({tag, "_hold_fin"}, bus.finished, 1);
                chk({tag, "_hold_wren"}, bus.oResultWren, 0);
                chk({tag, "_hold_busy"}, bus.busy, 0);
                @(negedge clock);
            end
            bus.start = 1'b0;
            @(negedge clock);
        end
        chk({tag, "_idle_fin"}, bus.finished, 0);
        chk({tag, "_idle_busy"}, bus.busy, 0);
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            img[i]  = 8'd100;
            mean[i] = 8'd100;
        end
        @(negedge clock);
        chk("rst_addr", {28'd0, bus.oImageRow, bus.oImageCol}, 0);
        chk("rst_wren", bus.oResultWren, 0);
        chk("rst_data", bus.oResultData, 0);
        chk("rst_col", bus.oResultCol, 0);
        chk("rst_row", bus.oResultRow, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fin", bus.finished, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_nostart_busy", bus.busy, 0);

        run("uniform", 1'b0);

        for (int i = 0; i < N; i++) begin
            img[i]  = 8'(16 * i);
            mean[i] = 8'd120;
        end
        run("gradient", 1'b0);

        for (int i = 0; i < N; i++) begin
            img[i]  = 8'(i % 3);
            mean[i] = 8'd1;
        end
        run("saturate", 1'b0);

        for (int i = 0; i < N; i++) begin
            img[i]  = 8'(37 * i + 5);
            mean[i] = 8'(255 - 29 * i);
        end
        run("mixed_hold", 1'b1);
        run("mixed_again", 1'b0);

        for (int i = 0; i < N; i++) begin
            img[i]  = 8'(16 * i);
            mean[i] = 8'd120;
        end
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (7) @(negedge clock);
        chk("midrun_wren_before", bus.oResultWren, 1);
        reset = 1'b0;
        #1;
        chk("midrun_wren", bus.oResultWren, 0);
        chk("midrun_busy", bus.busy, 0);
        chk("midrun_fin", bus.finished, 0);
        chk("midrun_addr", {28'd0, bus.oImageRow, bus.oImageCol}, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run("rerun", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
